color_capture_ctrl: RTL and testbench

- Sequencer for the colour-extract datapath: turns a raw push-button press into one frame-aligned capture of the 32x32 sampling window.
- Issues clear, accumulate, result-latch and detect-load strobes to the accumulator and detect-register logic.
- Sits between board I/O (button, clear switch) and the colour-detect datapath; timing comes from the video timing controller counters.

---
 rtl/color_capture_ctrl_if.sv | 26 ++
 rtl/color_capture_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_color_capture_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/color_capture_ctrl_if.sv
// Board-I/O, video-timing and datapath-strobe bundle around the colour capture sequencer.
// master = sequencer side, slave = board/timing/datapath side.
interface color_capture_ctrl_if;
  logic        btn_ColorExtract;
  logic        sw_ColorClear;
  logic [11:0] VtcHCnt;
  logic [10:0] VtcVCnt;
  logic        acc_clr;
  logic        acc_en;
  logic        res_latch;
  logic        det_load;
  logic        det_clear;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  btn_ColorExtract, sw_ColorClear, VtcHCnt, VtcVCnt,
    output acc_clr, acc_en, res_latch, det_load, det_clear, busy, done, err
  );

  modport slave (
    output btn_ColorExtract, sw_ColorClear, VtcHCnt, VtcVCnt,
    input  acc_clr, acc_en, res_latch, det_load, det_clear, busy, done, err
  );
endinterface

// File: rtl/color_capture_ctrl.sv
// Turns a debounced button press into one frame-aligned capture of the sampling window:
// clear, accumulate the window pixels, latch the result on RESULT_LINE, then load the detect register.
module color_capture_ctrl #(
  parameter int WIN_H0       = 144,
  parameter int WIN_V0       = 104,
  parameter int WIN_SIZE     = 32,
  parameter int RESULT_LINE  = 239,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int TIMEOUT_CYC  = 2000000
) (
  input  logic           PClk,
  input  logic           rst_n,
  color_capture_ctrl_if.master bus
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);
  localparam logic [11:0]   H_LO     = 12'(WIN_H0);
  localparam logic [11:0]   H_HI     = 12'(WIN_H0 + WIN_SIZE);
  localparam logic [10:0]   V_LO     = 11'(WIN_V0);
  localparam logic [10:0]   V_HI     = 11'(WIN_V0 + WIN_SIZE);
  localparam logic [10:0]   R_LINE   = 11'(RESULT_LINE);
  localparam logic [10:0]   PIX_FULL = 11'(WIN_SIZE * WIN_SIZE);
  localparam logic [10:0]   PIX_MAX  = 11'h7FF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    ACCUM,
    LATCH,
    LOAD
  } state_t;

  state_t        state;

  logic          btn_meta, btn_s, btn_stable, btn_stable_d;
  logic          sw_meta, sw_s;
  logic [DW-1:0] deb_cnt;

  logic          sof_raw, sof_raw_d, sof, rline, win_raw, press, in_wd;
  logic [10:0]   pix_cnt;
  logic [WW-1:0] wd_cnt;

  logic          acc_clr, acc_en, res_latch, det_load, busy, done, err;

  assign sof_raw = (bus.VtcVCnt == 11'd0) && (bus.VtcHCnt == 12'd0);
  assign win_raw = (bus.VtcHCnt >= H_LO) && (bus.VtcHCnt < H_HI) &&
                   (bus.VtcVCnt >= V_LO) && (bus.VtcVCnt < V_HI);
  assign press   = btn_stable && !btn_stable_d;
  assign in_wd   = (state == WAIT_SOF) || (state == ACCUM);

  // Input conditioning and timing decode; all of it registered.
  always_ff @(posedge PClk) begin
    if (!rst_n) begin
      btn_meta     <= 1'b0;
      btn_s        <= 1'b0;
      btn_stable   <= 1'b0;
      btn_stable_d <= 1'b0;
      sw_meta      <= 1'b0;
      sw_s         <= 1'b0;
      deb_cnt      <= '0;
      sof_raw_d    <= 1'b0;
      sof          <= 1'b0;
      rline        <= 1'b0;
    end else begin
      btn_meta     <= bus.btn_ColorExtract;
      btn_s        <= btn_meta;
      sw_meta      <= bus.sw_ColorClear;
      sw_s         <= sw_meta;
      btn_stable_d <= btn_stable;

      if (btn_s == btn_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_stable <= btn_s;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end

      // Rising-edge detect keeps a held 0/0 counter from producing repeated frame starts.
      sof_raw_d <= sof_raw;
      sof       <= sof_raw && !sof_raw_d;
      rline     <= (bus.VtcVCnt == R_LINE) && (bus.VtcHCnt == 12'd0);
    end
  end

  always_ff @(posedge PClk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      res_latch <= 1'b0;
      det_load  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      pix_cnt   <= '0;
      wd_cnt    <= '0;
    end else begin
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      res_latch <= 1'b0;
      det_load  <= 1'b0;
      done      <= 1'b0;

      if (acc_en && (pix_cnt != PIX_MAX)) begin
        pix_cnt <= pix_cnt + 11'd1;
      end
      wd_cnt <= in_wd ? wd_cnt + WW'(1) : '0;

      if ((state != IDLE) && sw_s) begin
        state  <= IDLE;
        busy   <= 1'b0;
        wd_cnt <= '0;
      end else if (in_wd && (wd_cnt == WD_LAST)) begin
        state  <= IDLE;
        busy   <= 1'b0;
        err    <= 1'b1;
        wd_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press && !sw_s) begin
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= WAIT_SOF;
            end
          end
          WAIT_SOF: begin
            if (sof) begin
              acc_clr <= 1'b1;
              pix_cnt <= '0;
              state   <= ACCUM;
            end
          end
          ACCUM: begin
            if (rline) begin
              res_latch <= 1'b1;
              state     <= LATCH;
            end else begin
              acc_en <= win_raw;
            end
          end
          LATCH: begin
            // A short or long pixel count means the frame timing was disturbed; the result is not trusted.
            if (pix_cnt != PIX_FULL) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              det_load <= 1'b1;
              done     <= 1'b1;
              state    <= LOAD;
            end
          end
          LOAD: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.acc_clr   = acc_clr;
  assign bus.acc_en    = acc_en;
  assign bus.res_latch = res_latch;
  assign bus.det_load  = det_load;
  assign bus.det_clear = sw_s;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;

  strobes_exclusive: assert property (@(posedge PClk) disable iff (!rst_n)
    $onehot0({acc_clr, acc_en, res_latch, det_load}));

  done_with_load: assert property (@(posedge PClk) disable iff (!rst_n)
    done |-> det_load);

endmodule

// File: tb/tb_color_capture_ctrl.sv
// Directed bench for color_capture_ctrl using a compressed frame scan that hits every decode point.
module tb_color_capture_ctrl;

  localparam int DEB = 16;
  // Must exceed the 1024-cycle window scan plus the compressed frame overhead.
  localparam int TMO = 1500;

  logic PClk;
  logic rst_n;

  color_capture_ctrl_if bus ();

  color_capture_ctrl #(
    .WIN_H0      (144),
    .WIN_V0      (104),
    .WIN_SIZE    (32),
    .RESULT_LINE (239),
    .DEBOUNCE_CYC(DEB),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .PClk (PClk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial PClk = 1'b0;
  always #5 PClk = ~PClk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc, n_clr, n_en, n_runs, n_latch, n_load, n_done, n_busy, n_ovl;
  int t_clr, t_latch, t_load, t_done, t_fall, t_sof, t_rline;
  int first_h, first_v;
  logic prev_en, prev_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_mon();
    n_clr = 0; n_en = 0; n_runs = 0; n_latch = 0; n_load = 0; n_done = 0;
    n_busy = 0; n_ovl = 0;
    t_clr = -1; t_latch = -1; t_load = -1; t_done = -1; t_fall = -1;
    first_h = -1; first_v = -1;
  endtask

  // Advance one cycle, then sample the registered outputs produced from the inputs just applied.
  task automatic tick();
    @(posedge PClk);
    #1;
    cyc++;
    if (bus.acc_clr) begin n_clr++; t_clr = cyc; end
    if (bus.acc_en) begin
      if (!prev_en) n_runs++;
      if (n_en == 0) begin first_h = int'(bus.VtcHCnt); first_v = int'(bus.VtcVCnt); end
      n_en++;
    end
    prev_en = bus.acc_en;
    if (bus.res_latch) begin n_latch++; t_latch = cyc; end
    if (bus.det_load)  begin n_load++;  t_load  = cyc; end
    if (bus.done)      begin n_done++;  t_done  = cyc; end
    if (bus.busy) n_busy++;
    if (prev_busy && !bus.busy) t_fall = cyc;
    prev_busy = bus.busy;
    if ($countones({bus.acc_clr, bus.acc_en, bus.res_latch, bus.det_load}) > 1) n_ovl++;
  endtask

  task automatic cyc_hv(input int h, input int v);
    bus.VtcHCnt = 12'(h);
    bus.VtcVCnt = 11'(v);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_hv(5, 50);
  endtask

  task automatic press();
    bus.btn_ColorExtract = 1'b1;
    for (int i = 0; i < 60 && !bus.busy; i++) cyc_hv(5, 50);
    check("press_accept", bus.busy, 1'b1);
    bus.btn_ColorExtract = 1'b0;
  endtask

  // sof, a few blank cycles, n_lines window lines (H 143..176), then the result line if complete.
  task automatic frame(input int trunc_line, input int n_lines);
    cyc_hv(0, 0);
    t_sof = cyc;
    repeat (3) cyc_hv(5, 1);
    for (int v = 104; v < 104 + n_lines; v++) begin
      for (int h = 143; h <= 176; h++) begin
        if (!(v == trunc_line && h >= 160 && h <= 169)) cyc_hv(h, v);
      end
    end
    if (n_lines == 32) begin
      cyc_hv(0, 239);
      t_rline = cyc;
      cyc_hv(1, 239);
      repeat (4) cyc_hv(2, 240);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.acc_clr, bus.acc_en, bus.res_latch, bus.det_load,
            bus.det_clear, bus.busy, bus.done, bus.err};
  endfunction

  initial begin
    cyc = 0; prev_en = 1'b0; prev_busy = 1'b0;
    reset_mon();
    bus.btn_ColorExtract = 1'b0;
    bus.sw_ColorClear    = 1'b0;
    bus.VtcHCnt          = 12'd5;
    bus.VtcVCnt          = 11'd50;
    rst_n                = 1'b0;

    // Reset state
    idle(2);
    check("reset_outputs", outs(), 8'h00);
    rst_n = 1'b1;
    idle(4);
    check("post_reset_outputs", outs(), 8'h00);

    // Clean press, full capture
    reset_mon();
    press();
    frame(0, 32);
    idle(5);
    check("clean_acc_clr_count", n_clr, 1);
    check("clean_acc_clr_at_sof", t_clr, t_sof + 1);
    check("clean_acc_en_count", n_en, 1024);
    check("clean_acc_en_runs", n_runs, 32);
    check("clean_first_h", first_h, 144);
    check("clean_first_v", first_v, 104);
    check("clean_res_latch_count", n_latch, 1);
    check("clean_res_latch_time", t_latch, t_rline + 1);
    check("clean_det_load_time", t_load, t_latch + 1);
    check("clean_done_time", t_done, t_load);
    check("clean_busy_fall", t_fall, t_load + 1);
    check("clean_err", bus.err, 1'b0);
    check("clean_overlap", n_ovl, 0);
    idle(30);

    // Bouncy press, then a release/re-press while busy
    reset_mon();
    for (int i = 0; i < 10; i++) begin
      bus.btn_ColorExtract = ~bus.btn_ColorExtract;
      idle(5);
    end
    check("bounce_no_early_busy", n_busy, 0);
    press();
    idle(25);
    bus.btn_ColorExtract = 1'b1;
    idle(25);
    bus.btn_ColorExtract = 1'b0;
    idle(25);
    frame(0, 32);
    idle(40);
    check("bounce_acc_clr_count", n_clr, 1);
    check("bounce_det_load_count", n_load, 1);
    check("bounce_done_count", n_done, 1);
    check("bounce_busy_after", bus.busy, 1'b0);

    // Clear switch raised mid-accumulation
    reset_mon();
    press();
    frame(0, 6);
    bus.sw_ColorClear = 1'b1;
    cyc_hv(150, 110);
    check("sw_sync_1", bus.det_clear, 1'b0);
    cyc_hv(151, 110);
    check("sw_sync_2", bus.det_clear, 1'b1);
    check("sw_busy_before_abort", bus.busy, 1'b1);
    cyc_hv(152, 110);
    check("sw_abort_busy", bus.busy, 1'b0);
    reset_mon();
    frame(0, 32);
    bus.btn_ColorExtract = 1'b1;
    idle(30);
    bus.btn_ColorExtract = 1'b0;
    idle(30);
    check("sw_no_busy", n_busy, 0);
    check("sw_no_acc", n_clr + n_en, 0);
    check("sw_no_latch", n_latch + n_load + n_done, 0);
    check("sw_det_clear_held", bus.det_clear, 1'b1);
    check("sw_err", bus.err, 1'b0);
    bus.sw_ColorClear = 1'b0;
    idle(3);
    check("sw_det_clear_release", bus.det_clear, 1'b0);

    // Timing stall leading to watchdog abort
    reset_mon();
    press();
    idle(TMO + 100);
    check("stall_busy_cycles", n_busy, TMO);
    check("stall_err", bus.err, 1'b1);
    check("stall_busy", bus.busy, 1'b0);
    check("stall_no_strobes", n_clr + n_en + n_latch + n_load + n_done, 0);
    reset_mon();
    press();
    check("stall_err_cleared", bus.err, 1'b0);
    frame(0, 32);
    idle(5);
    check("stall_recover_load", n_load, 1);
    check("stall_recover_err", bus.err, 1'b0);

    // Truncated window line
    reset_mon();
    press();
    frame(110, 32);
    idle(5);
    check("trunc_acc_en_count", n_en, 1014);
    check("trunc_res_latch", n_latch, 1);
    check("trunc_no_load", n_load + n_done, 0);
    check("trunc_err", bus.err, 1'b1);
    check("trunc_busy", bus.busy, 1'b0);

    // Reset pulse during accumulation
    reset_mon();
    press();
    frame(0, 10);
    rst_n = 1'b0;
    cyc_hv(150, 114);
    check("midrst_outputs", outs(), 8'h00);
    rst_n = 1'b1;
    reset_mon();
    frame(0, 32);
    idle(5);
    check("midrst_no_acc", n_clr + n_en, 0);
    check("midrst_no_busy", n_busy, 0);
    reset_mon();
    press();
    frame(0, 32);
    idle(5);
    check("midrst_recover_en", n_en, 1024);
    check("midrst_recover_load", n_load, 1);
    check("midrst_overlap", n_ovl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
